// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide scheduler: EX op codes, FSM states
// and the fixed divide iteration count.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } ex_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_sched_div_iter.sv
// Restoring radix-2 unsigned divider producing one quotient bit per cycle.
// quot/rem are the post-step values, so they are final while done is high.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        done
);

  logic        active;
  logic [4:0]  cnt;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dsr_r;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_n;
  logic [31:0] quo_n;

  // The dividend is shifted out of quo_r from the top while quotient bits
  // enter at the bottom.
  assign shifted = {rem_r, quo_r[31]};
  assign ge      = shifted >= {1'b0, dsr_r};
  assign rem_n   = ge ? (shifted[31:0] - dsr_r) : shifted[31:0];
  assign quo_n   = {quo_r[30:0], ge};

  assign quot = quo_n;
  assign rem  = rem_n;
  assign done = active && (cnt == 5'(DIV_ITERS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      cnt    <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      dsr_r  <= '0;
    end else if (cancel) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem_r  <= '0;
      quo_r  <= dividend;
      dsr_r  <= divisor;
    end else if (active) begin
      rem_r <= rem_n;
      quo_r <= quo_n;
      cnt   <= cnt + 5'd1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// Multiply/divide scheduler and HI/LO owner sitting beside the EX stage.
// Stalls the pipeline while an operation is in flight or HI/LO is stale.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_src_a,
  input  logic [31:0] ex_src_b,
  input  logic        ex_rd_hilo,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e        state;
  state_e        next_state;
  logic [CW-1:0] mul_cnt;
  logic [63:0]   mul_pipe [MUL_CYCLES];
  logic [63:0]   mul_ext_a;
  logic [63:0]   mul_ext_b;
  logic [63:0]   mul_prod;
  logic          mul_sgn;
  logic          div_sgn;
  logic          is_mul_op;
  logic          is_div_op;
  logic          issue_mul;
  logic          issue_div;
  logic          mul_last;
  logic          in_flight;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic          div_neg_a;
  logic          div_neg_b;
  logic          div_b_zero;
  logic [31:0]   div_a;
  logic [31:0]   div_quot;
  logic [31:0]   div_rem;
  logic          div_done;
  logic [31:0]   q_fix;
  logic [31:0]   r_fix;

  assign is_mul_op = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
  assign is_div_op = (ex_op == OP_DIV)  || (ex_op == OP_DIVU);
  assign mul_sgn   = (ex_op == OP_MULT);
  assign div_sgn   = (ex_op == OP_DIV);
  assign issue_mul = (state == ST_IDLE) && ex_valid && !flush && is_mul_op;
  assign issue_div = (state == ST_IDLE) && ex_valid && !flush && is_div_op;
  assign in_flight = (state == ST_MUL) || (state == ST_DIV);
  assign mul_last  = (mul_cnt == CW'(MUL_CYCLES - 1));

  assign stall_req = !flush && (issue_mul || issue_div ||
                                (in_flight && (ex_valid || ex_rd_hilo)));

  // One multiplier on the EX operands; the product then ripples through the
  // pipe so synthesis is free to retime the multiplier across those stages.
  assign mul_ext_a = {{32{mul_sgn & ex_src_a[31]}}, ex_src_a};
  assign mul_ext_b = {{32{mul_sgn & ex_src_b[31]}}, ex_src_b};
  assign mul_prod  = mul_ext_a * mul_ext_b;

  assign abs_a = (div_sgn && ex_src_a[31]) ? -ex_src_a : ex_src_a;
  assign abs_b = (div_sgn && ex_src_b[31]) ? -ex_src_b : ex_src_b;
  assign q_fix = (div_neg_a ^ div_neg_b) ? -div_quot : div_quot;
  assign r_fix = div_neg_a ? -div_rem : div_rem;

  div_iter u_div_iter (
    .clk      (clk),
    .resetn   (resetn),
    .start    (issue_div),
    .cancel   (flush),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (issue_mul)      next_state = ST_MUL;
        else if (issue_div) next_state = ST_DIV;
      end
      ST_MUL: begin
        if (flush)         next_state = ST_IDLE;
        else if (mul_last) next_state = ST_DONE;
      end
      ST_DIV: begin
        if (flush)         next_state = ST_IDLE;
        else if (div_done) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      mul_cnt <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ST_MUL) || (next_state == ST_DIV);
      if (issue_mul)            mul_cnt <= '0;
      else if (state == ST_MUL) mul_cnt <= mul_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MUL_CYCLES; i++) mul_pipe[i] <= '0;
    end else begin
      if (issue_mul) mul_pipe[0] <= mul_prod;
      for (int i = 1; i < MUL_CYCLES; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_neg_a  <= 1'b0;
      div_neg_b  <= 1'b0;
      div_b_zero <= 1'b0;
      div_a      <= '0;
    end else if (issue_div) begin
      div_neg_a  <= div_sgn & ex_src_a[31];
      div_neg_b  <= div_sgn & ex_src_b[31];
      div_b_zero <= (ex_src_b == 32'd0);
      div_a      <= ex_src_a;
    end
  end

  // A flush suppresses every HI/LO write at its edge, completion included.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (ex_valid && (ex_op == OP_MTHI))      hi <= ex_src_a;
          else if (ex_valid && (ex_op == OP_MTLO)) lo <= ex_src_a;
        end
        ST_MUL: begin
          if (mul_last) {hi, lo} <= mul_pipe[MUL_CYCLES-1];
        end
        ST_DIV: begin
          if (div_done) begin
            if (div_b_zero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= div_a;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: directed scenarios plus randomized back-to-back ops
// scored against an arithmetic HI/LO model.
module tb_muldiv_sched;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op = 3'd0;
  logic [31:0] ex_src_a = '0;
  logic [31:0] ex_src_b = '0;
  logic        ex_rd_hilo = 1'b0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_sched #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_src_a   (ex_src_a),
    .ex_src_b   (ex_src_b),
    .ex_rd_hilo (ex_rd_hilo),
    .flush      (flush),
    .stall_req  (stall_req),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_md(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic int exp_stalls(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MUL_CYCLES + 1;
    if (op == 3'd3 || op == 3'd4) return 33;
    return 0;
  endfunction

  // Architectural MIPS semantics of each op on HI/LO.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    int          ia;
    int          ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
      3'd3: begin
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 32'd0; end
        else begin m_lo = 32'(ia / ib); m_hi = 32'(ia % ib); end
      end
      3'd4: begin
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
    if (is_md(op)) exp_q.push_back({m_hi, m_lo});
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_src_a = a;
    ex_src_b = b;
  endtask

  // Presents one instruction in EX until it advances, then scores it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int stalls;
    bit timed_out;
    bit busy_bad;
    stalls = 0;
    timed_out = 1'b1;
    busy_bad = 1'b0;
    model_apply(op, a, b);
    issue(op, a, b);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall_req) begin
        timed_out = 1'b0;
        break;
      end
      if (busy !== (i != 0)) busy_bad = 1'b1;
      stalls++;
      @(negedge clk);
    end
    check("timeout", 64'(timed_out), 64'd0);
    check("stall_cycles", 64'(stalls), 64'(exp_stalls(op)));
    if (is_md(op)) begin
      check("busy_in_flight", 64'(busy_bad), 64'd0);
      check("busy_done", 64'(busy), 64'd0);
      check("hilo_done", {hi, lo}, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_op    = 3'd0;
    if (!is_md(op)) check("hilo_mt", {hi, lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    bit to;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed arithmetic cases
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7by2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd4, 32'hFFFF_FFFF, 32'd0);
    check("divu_by0", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(3'd3, 32'hFFFF_FF00, 32'd0);
    check("div_by0_signed", {hi, lo}, 64'hFFFF_FF00_FFFF_FFFF);

    // Flush at DIV cycle 10, then an immediate MULTU
    model_apply(3'd3, 32'd100, 32'd7);
    void'(exp_q.pop_back());
    m_hi = 32'hFFFF_FF00;
    m_lo = 32'hFFFF_FFFF;
    issue(3'd3, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall_req), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    ex_valid = 1'b0;
    check("flush_div_hilo", {hi, lo}, 64'hFFFF_FF00_FFFF_FFFF);
    check("flush_div_busy", 64'(busy), 64'd0);
    run_op(3'd2, 32'd2, 32'd3);
    check("multu_after_flush", {hi, lo}, 64'd6);

    // MTHI updates at the next edge without stalling
    run_op(3'd5, 32'h1234_5678, 32'd0);
    check("mthi", 64'(hi), 64'h1234_5678);

    // MFHI behind a MULT waits for DONE
    model_apply(3'd1, 32'hFFFF_0000, 32'h0001_0000);
    issue(3'd1, 32'hFFFF_0000, 32'h0001_0000);
    n = 0;
    to = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (!stall_req) begin
        to = 1'b0;
        break;
      end
      n++;
      @(negedge clk);
      ex_valid = 1'b0;
      ex_rd_hilo = 1'b1;
      #1;
    end
    check("mfhi_timeout", 64'(to), 64'd0);
    check("mfhi_stall_cycles", 64'(n), 64'(MUL_CYCLES + 1));
    check("mfhi_hilo", {hi, lo}, exp_q.pop_front());
    @(posedge clk);
    #1;
    check("mfhi_idle_nostall", 64'(stall_req), 64'd0);
    ex_rd_hilo = 1'b0;

    // Flush coinciding with MULT completion keeps prior HI/LO
    model_apply(3'd1, 32'd7, 32'd9);
    void'(exp_q.pop_back());
    {m_hi, m_lo} = {hi, lo};
    issue(3'd1, 32'd7, 32'd9);
    repeat (MUL_CYCLES) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_mul_stall", 64'(stall_req), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    ex_valid = 1'b0;
    check("flush_mul_hilo", {hi, lo}, {m_hi, m_lo});
    check("flush_mul_busy", 64'(busy), 64'd0);

    // Randomized back-to-back traffic
    for (int k = 0; k < 24; k++) begin
      run_op(3'($urandom_range(1, 6)), pick(), pick());
    end

    // Reset asserted at DIV cycle 5
    issue(3'd4, 32'd1000, 32'd3);
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_stall", 64'(stall_req), 64'd0);
    m_hi = '0;
    m_lo = '0;
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    run_op(3'd2, 32'd6, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
